// File: rtl/hubris_uart_tx_buffer.sv
// Byte FIFO feeding an 8N1 UART serializer (LSB first, idle-high line).
// Define HUBRIS_UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module hubris_uart_tx_buffer #(
    parameter int CLKS_PER_BIT     = 54,
    parameter int BUFFER_BYTE_SIZE = 64
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                wr_en,
    input  logic [7:0]                          wr_data,
    output logic                                full,
    output logic                                empty,
    output logic [$clog2(BUFFER_BYTE_SIZE):0]   count,
    output logic                                busy,
    output logic                                tx
);

    localparam int AW = $clog2(BUFFER_BYTE_SIZE);
    localparam int PW = AW + 1;
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [PW-1:0] DEPTH_P   = PW'(BUFFER_BYTE_SIZE);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef HUBRIS_UART_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } state_t;

    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction

    logic [7:0]    mem_r [BUFFER_BYTE_SIZE];
    logic [PW-1:0] wr_ptr_r, rd_ptr_r, count_r;
    logic [PW-1:0] wr_ptr_next_s, rd_ptr_next_s, count_next_s;
    logic          full_r, empty_r;
    logic          push_s, pop_s;
    logic [7:0]    head_s;

    state_t        state_r, state_next_s;
    logic [BW-1:0] baud_cnt_r, baud_next_s;
    logic [2:0]    bit_idx_r, bit_next_s;
    logic [7:0]    data_r;
    logic          tx_r, tx_next_s, busy_r;
    logic          bit_end_s;

    assign full   = full_r;
    assign empty  = empty_r;
    assign count  = count_r;
    assign busy   = busy_r;
    assign tx     = tx_r;
    assign head_s = mem_r[rd_ptr_r[AW-1:0]];
    assign bit_end_s = (baud_cnt_r == BAUD_LAST);

    // Pointer arithmetic; a push against a full FIFO is dropped even when a pop lands on the same edge.
    always_comb begin
        push_s        = wr_en && !full_r;
        wr_ptr_next_s = push_s ? (wr_ptr_r + PW'(1)) : wr_ptr_r;
        rd_ptr_next_s = pop_s  ? (rd_ptr_r + PW'(1)) : rd_ptr_r;
        count_next_s  = wr_ptr_next_s - rd_ptr_next_s;
    end

    // FIFO storage.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
        end
    end

    // FIFO pointers and registered status flags.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            wr_ptr_r <= wr_ptr_next_s;
            rd_ptr_r <= rd_ptr_next_s;
            count_r  <= count_next_s;
            full_r   <= (count_next_s == DEPTH_P);
            empty_r  <= (count_next_s == '0);
        end
    end

    // Serializer state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Serializer next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE:  state_next_s = empty_r ? ST_IDLE : ST_START;
            ST_START: state_next_s = bit_end_s ? ST_DATA : ST_START;
            ST_DATA: begin
                if (bit_end_s && (bit_idx_r == 3'd7)) begin
`ifdef HUBRIS_UART_TX_PARITY_EN
                    state_next_s = ST_PARITY;
`else
                    state_next_s = ST_STOP;
`endif
                end else begin
                    state_next_s = ST_DATA;
                end
            end
`ifdef HUBRIS_UART_TX_PARITY_EN
            ST_PARITY: state_next_s = bit_end_s ? ST_STOP : ST_PARITY;
`endif
            ST_STOP: begin
                if (bit_end_s) begin
                    state_next_s = empty_r ? ST_IDLE : ST_START;
                end else begin
                    state_next_s = ST_STOP;
                end
            end
            default:  state_next_s = ST_IDLE;
        endcase
    end

    // Serializer outputs: pop strobe, next line level and counter updates.
    always_comb begin
        pop_s       = 1'b0;
        tx_next_s   = tx_r;
        baud_next_s = bit_end_s ? '0 : (baud_cnt_r + BW'(1));
        bit_next_s  = bit_idx_r;
        case (state_r)
            ST_IDLE: begin
                baud_next_s = '0;
                bit_next_s  = 3'd0;
                if (!empty_r) begin
                    pop_s     = 1'b1;
                    tx_next_s = 1'b0;
                end else begin
                    tx_next_s = 1'b1;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    bit_next_s = 3'd0;
                    tx_next_s  = data_r[0];
                end else begin
                    tx_next_s  = 1'b0;
                end
            end
            ST_DATA: begin
                if (bit_end_s && (bit_idx_r == 3'd7)) begin
`ifdef HUBRIS_UART_TX_PARITY_EN
                    tx_next_s = even_parity(data_r);
`else
                    tx_next_s = 1'b1;
`endif
                end else if (bit_end_s) begin
                    bit_next_s = bit_idx_r + 3'd1;
                    tx_next_s  = data_r[bit_idx_r + 3'd1];
                end else begin
                    tx_next_s  = tx_r;
                end
            end
`ifdef HUBRIS_UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end_s) begin
                    tx_next_s = 1'b1;
                end else begin
                    tx_next_s = tx_r;
                end
            end
`endif
            ST_STOP: begin
                // Back-to-back frames: the next start bit begins right after this stop bit.
                if (bit_end_s && !empty_r) begin
                    pop_s     = 1'b1;
                    tx_next_s = 1'b0;
                end else begin
                    tx_next_s = 1'b1;
                end
            end
            default: begin
                baud_next_s = '0;
                tx_next_s   = 1'b1;
            end
        endcase
    end

    // Serializer datapath registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            baud_cnt_r <= '0;
            bit_idx_r  <= 3'd0;
            data_r     <= 8'd0;
            tx_r       <= 1'b1;
            busy_r     <= 1'b0;
        end else begin
            baud_cnt_r <= baud_next_s;
            bit_idx_r  <= bit_next_s;
            if (pop_s) begin
                data_r <= head_s;
            end
            tx_r       <= tx_next_s;
            busy_r     <= (state_next_s != ST_IDLE);
        end
    end

endmodule
